// File: rtl/qos_credit_gen.sv
// Token-bucket credit source for one QoS class: periodic refill, handshake debit, saturation.
// Optional credit return path enabled by defining QOS_CREDIT_RETURN_EN.
module qos_credit_gen #(
    parameter int unsigned CREDIT_W      = 32,
    parameter int unsigned MAX_CREDIT    = 1024,
    parameter int unsigned INIT_CREDIT   = 1024,
    parameter int unsigned REFILL_AMT    = 16,
    parameter int unsigned REFILL_PERIOD = 8,
    parameter int unsigned REQ_W         = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                req_valid,
    input  logic [REQ_W-1:0]    req_amt,
    output logic                req_ready,
`ifdef QOS_CREDIT_RETURN_EN
    input  logic                ret_valid,
    input  logic [REQ_W-1:0]    ret_amt,
`endif
    output logic [CREDIT_W-1:0] avail_credit,
    output logic                empty,
    output logic                refill_tick,
    output logic                clip
);

    localparam int unsigned PCNT_W = (REFILL_PERIOD > 1) ? $clog2(REFILL_PERIOD) : 1;
    localparam int unsigned SUM_W  = CREDIT_W + 2;

    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(REFILL_PERIOD - 1);
    localparam logic [SUM_W-1:0]  MAX_S     = SUM_W'(MAX_CREDIT);
    localparam logic [SUM_W-1:0]  REFILL_S  = SUM_W'(REFILL_AMT);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                empty_q, empty_d;
    logic                tick_q, tick_d;
    logic                clip_q, clip_d;

    logic                rf;
    logic [SUM_W-1:0]    debit;
    logic [SUM_W-1:0]    refill;
    logic [SUM_W-1:0]    ret_term;
    logic [SUM_W-1:0]    sum;

    // Grant looks only at registered credit, so same-cycle refill/return cannot enable it.
    assign req_ready = enable && (SUM_W'(req_amt) <= SUM_W'(credit_q));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (enable)  state_d = ST_RUN;
            ST_RUN:  if (!enable) state_d = ST_IDLE;
        endcase
    end

    // Period counter holds its phase while paused in IDLE.
    always_comb begin
        rf     = (state_q == ST_RUN) && (pcnt_q == PCNT_LAST);
        pcnt_d = pcnt_q;
        if (state_q == ST_RUN) begin
            pcnt_d = rf ? '0 : pcnt_q + PCNT_W'(1);
        end
    end

    always_comb begin
        debit    = (req_valid && req_ready) ? SUM_W'(req_amt) : '0;
        refill   = rf ? REFILL_S : '0;
`ifdef QOS_CREDIT_RETURN_EN
        ret_term = ret_valid ? SUM_W'(ret_amt) : '0;
`else
        ret_term = '0;
`endif
        // Debit never exceeds registered credit, so the sum cannot underflow.
        sum      = SUM_W'(credit_q) - debit + refill + ret_term;
        clip_d   = (sum > MAX_S);
        credit_d = clip_d ? CREDIT_W'(MAX_CREDIT) : sum[CREDIT_W-1:0];
        empty_d  = (credit_d == '0);
        tick_d   = rf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            pcnt_q   <= '0;
            credit_q <= CREDIT_W'(INIT_CREDIT);
            empty_q  <= 1'(INIT_CREDIT == 0);
            tick_q   <= 1'b0;
            clip_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pcnt_q   <= pcnt_d;
            credit_q <= credit_d;
            empty_q  <= empty_d;
            tick_q   <= tick_d;
            clip_q   <= clip_d;
        end
    end

    assign avail_credit = credit_q;
    assign empty        = empty_q;
    assign refill_tick  = tick_q;
    assign clip         = clip_q;

endmodule

// File: doc/qos_credit_gen.md
# qos_credit_gen

Token-bucket credit source that generates the `avail_credit` count consumed by the `qos` arbitration block. It replenishes credit at a fixed rate up to a ceiling, debits credit on granted requests through a valid/ready handshake, and optionally absorbs credit returned from downstream. It sits on the credit-issuing side of the `qos` interface, one instance per QoS class.

## Interface
- `CREDIT_W`, 32: width of `avail_credit` and the internal arithmetic base.
- `MAX_CREDIT`, 1024: saturation ceiling. Must satisfy `MAX_CREDIT` < 2^`CREDIT_W`.
- `INIT_CREDIT`, 1024: value loaded at reset. Must be ≤ `MAX_CREDIT`.
- `REFILL_AMT`, 16: credit added per refill period.
- `REFILL_PERIOD`, 8: cycles between refills. Must be ≥ 1.
- `REQ_W`, 16: width of `req_amt` and `ret_amt`.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `enable`, in, 1: run/stop for the refill engine.
- `req_valid`, in, 1: debit request.
- `req_amt`, in, `REQ_W`: credit to debit.
- `req_ready`, out, 1: request granted this cycle.
- `ret_valid`, in, 1: credit return. Present only with `QOS_CREDIT_RETURN_EN`.
- `ret_amt`, in, `REQ_W`: returned credit amount. Present only with `QOS_CREDIT_RETURN_EN`.
- `avail_credit`, out, `CREDIT_W`: current credit, registered.
- `empty`, out, 1: high when `avail_credit` == 0, registered.
- `refill_tick`, out, 1: one-cycle pulse when a refill is applied.
- `clip`, out, 1: one-cycle pulse when saturation discarded credit.

## Operation
- Two-state FSM:
  - IDLE: entered on reset. Moves to RUN when `enable`=1.
  - RUN: moves to IDLE when `enable`=0.
- Period counter `pcnt`:
  - Width is clog2(`REFILL_PERIOD`), minimum 1.
  - Counts 0..`REFILL_PERIOD`-1 in RUN only.
  - Held in IDLE, not cleared, so the refill phase survives a pause.
  - Refill event `rf` = RUN and `pcnt`==`REFILL_PERIOD`-1. On `rf`, `pcnt` wraps to 0.
- Grant rule: `req_ready` = `enable` and (`req_amt` ≤ `avail_credit`).
  - Combinational from the registered credit, so it is independent of same-cycle refill or return.
  - A zero-amount request is always granted while enabled.
  - No partial grants. Requests are not queued. The requester holds `req_valid` until ready.
- Debit `d` = `req_amt` if `req_valid` and `req_ready`, else 0.
- Update:
  - sum = `avail_credit` − `d` + (`rf` ? `REFILL_AMT` : 0) + (return accepted ? `ret_amt` : 0).
  - sum is computed in `CREDIT_W`+2 bits and cannot underflow, because `d` ≤ `avail_credit`.
  - next `avail_credit` = min(sum, `MAX_CREDIT`).
  - `clip` = 1 for one cycle if sum > `MAX_CREDIT`.
- Simultaneous debit, refill and return in one cycle: all terms apply in the same update; saturation is applied last.
- In IDLE, debits are blocked. Returns are still accepted when the macro is enabled.

## Timing
- Reset (asynchronous assert, synchronous deassert by the upstream reset synchroniser):
  - `avail_credit`=`INIT_CREDIT`.
  - `empty`=(`INIT_CREDIT`==0).
  - `refill_tick`=0, `clip`=0.
  - `pcnt`=0, FSM=IDLE.
  - `req_ready` follows its combinational equation, so it is 0 while `enable`=0.
- Reset asserted mid-operation discards all pending state immediately. Any in-flight grant is lost.
- One-cycle latency: a grant, refill or return in cycle N is visible on `avail_credit` in cycle N+1.
- `refill_tick`, `clip` and `empty` are registered and align with the updated `avail_credit`.
- After `enable` rises in cycle 0, the first `refill_tick` appears in cycle `REFILL_PERIOD`+1, given `pcnt`=0 at the start.
- Steady full rate: one `refill_tick` every `REFILL_PERIOD` cycles while in RUN.

## Configuration
- `QOS_CREDIT_RETURN_EN` defined:
  - `ret_valid` and `ret_amt` ports exist.
  - Returned credit is added in the same update as debit and refill.
- `QOS_CREDIT_RETURN_EN` undefined:
  - Ports are absent and the return term is 0.
  - The block is a pure rate limiter.

## Test plan
Default parameters apply unless stated.
- Reset with `enable`=0 → `avail_credit`=1024, `empty`=0, `req_ready`=0. After release, `req_valid`=1 with `req_amt`=4 → no grant and no change.
- `enable`=1 at full credit, no requests → `refill_tick` every 8 cycles, `clip`=1 on each tick, `avail_credit` stays 1024.
- `INIT_CREDIT`=0, `enable`=1:
  - `req_amt`=16 is held until the first refill.
  - `avail_credit` 0→16 with `refill_tick`, then `req_ready`=1 that cycle.
  - Next cycle `avail_credit`=0 and `empty`=1.
- `avail_credit`=20, `req_amt`=10 granted in the same cycle as a refill → next `avail_credit`=26. `req_amt`=27 → `req_ready`=0.
- With `QOS_CREDIT_RETURN_EN`, `avail_credit`=1020, `ret_amt`=8 and a refill in the same cycle → `avail_credit`=1024, `clip`=1. Repeat with `enable`=0 and `ret_amt`=3 from 100 → 103.
- Assert `rst_n`=0 mid-run at `avail_credit`=37, `pcnt`=5 → immediately `avail_credit`=1024 and `pcnt`=0. After release, the first tick comes 8 cycles after the RUN cycle that follows `enable`.
